// File: rtl/wb_mem_arbiter_if.sv
// wb_mem_arbiter_if: requester-side and Wishbone-side signals of the memory arbiter
interface wb_mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int BUS_WIDTH = 128
);
  logic [NUM_PORTS-1:0] valid, wr, ready, err;
  logic [32*NUM_PORTS-1:0] addr, datain, dataout;
  logic [31:0] wb_adr_o;
  logic [BUS_WIDTH-1:0] wb_dat_o, wb_dat_i;
  logic [BUS_WIDTH/8-1:0] wb_sel_o;
  logic wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i, wb_rty_i;
  modport master (
    input valid, addr, datain, wr, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output dataout, ready, err, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
  modport slave (
    output valid, addr, datain, wr, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input dataout, ready, err, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: grants one of NUM_PORTS word requests onto a Wishbone classic bus with retry and timeout
module wb_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int BUS_WIDTH = 128,
  parameter int RR_MODE = 1,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  wb_mem_arbiter_if.master bus
);
  localparam int NL = BUS_WIDTH / 32;
  localparam int SW = BUS_WIDTH / 8;
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int LW = NL > 1 ? $clog2(NL) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, BUS, RETRY, RESP} state_t;
  state_t state, nxt;
  logic [PW-1:0] port, last, win, cand;
  logic [LW-1:0] lane, wlane;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic [31:0] waddr;
  logic found, grant, done_ok, done_err, retry, tmo;
  assign waddr = bus.addr[32*win +: 32];
  assign wlane = NL > 1 ? LW'(waddr >> 2) : '0;
  assign tmo = TIMEOUT != 0 && int'(tcnt) + 1 == TIMEOUT;
  assign bus.wb_stb_o = bus.wb_cyc_o;
  // winner search: from the port after the last grant (round-robin) or from port 0 (fixed)
  always_comb begin
    win = '0;
    found = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PW'(RR_MODE != 0 ? (int'(last) + 1 + k) % NUM_PORTS : k);
      if (!found && bus.valid[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  // next state and termination decode, err beats ack beats rty beats timeout
  always_comb begin
    nxt = state;
    grant = 1'b0;
    done_ok = 1'b0;
    done_err = 1'b0;
    retry = 1'b0;
    case (state)
      IDLE: begin
        grant = found;
        nxt = found ? BUS : IDLE;
      end
      BUS: begin
        if (bus.wb_err_i) done_err = 1'b1;
        else if (bus.wb_ack_i) done_ok = 1'b1;
        else if (bus.wb_rty_i) begin
          retry = int'(rcnt) < MAX_RETRY;
          done_err = !retry;
        end else done_err = tmo;
        nxt = retry ? RETRY : (done_ok || done_err) ? RESP : BUS;
      end
      RETRY: nxt = BUS;
      default: nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // latched request, bus outputs, counters and response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      port <= '0;
      last <= PW'(NUM_PORTS - 1);
      lane <= '0;
      rcnt <= '0;
      tcnt <= '0;
      bus.ready <= '0;
      bus.err <= '0;
      bus.dataout <= '0;
      bus.wb_adr_o <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_sel_o <= '0;
      bus.wb_we_o <= 1'b0;
      bus.wb_cyc_o <= 1'b0;
    end else begin
      bus.ready <= '0;
      bus.err <= '0;
      bus.wb_cyc_o <= nxt == BUS;
      tcnt <= state == BUS ? tcnt + 1'b1 : '0;
      rcnt <= grant ? '0 : retry ? rcnt + 1'b1 : rcnt;
      if (grant) begin
        port <= win;
        last <= win;
        lane <= wlane;
        bus.wb_adr_o <= waddr & ~32'(SW - 1);
        bus.wb_sel_o <= SW'(4'hF) << (4 * wlane);
        bus.wb_dat_o <= {NL{bus.datain[32*win +: 32]}};
        bus.wb_we_o <= bus.wr[win];
      end
      if (done_ok) begin
        bus.ready[port] <= 1'b1;
        if (!bus.wb_we_o) bus.dataout[32*port +: 32] <= bus.wb_dat_i[32*lane +: 32];
      end
      if (done_err) bus.err[port] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: randomized bench checking a round-robin and a fixed-priority arbiter against a rule-level model
module tb_wb_mem_arbiter;
  localparam int NP = 3, BW = 128, NL = BW / 32, SW = BW / 8, MR = 3, TO = 8;
  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] valid, wr;
  logic [32*NP-1:0] addr, datain;
  logic [BW-1:0] rdat;
  logic ack, berr, rty;
  int checks = 0, failures = 0;
  int last_rr;
  logic [31:0] exp_dout [2][NP];
  int rq[$];
  logic [NP-1:0] rdy [2], er [2];
  logic [32*NP-1:0] dout [2];
  logic cyc [2], stb [2], we [2];
  logic [31:0] adr [2];
  logic [SW-1:0] sel [2];
  logic [BW-1:0] wdat [2];

  wb_mem_arbiter_if #(.NUM_PORTS(NP), .BUS_WIDTH(BW)) a (), f ();
  assign {a.valid, a.wr, a.addr, a.datain, a.wb_dat_i, a.wb_ack_i, a.wb_err_i, a.wb_rty_i} = {valid, wr, addr, datain, rdat, ack, berr, rty};
  assign {f.valid, f.wr, f.addr, f.datain, f.wb_dat_i, f.wb_ack_i, f.wb_err_i, f.wb_rty_i} = {valid, wr, addr, datain, rdat, ack, berr, rty};
  assign {rdy[0], er[0], dout[0], cyc[0], stb[0], we[0], adr[0], sel[0], wdat[0]} = {a.ready, a.err, a.dataout, a.wb_cyc_o, a.wb_stb_o, a.wb_we_o, a.wb_adr_o, a.wb_sel_o, a.wb_dat_o};
  assign {rdy[1], er[1], dout[1], cyc[1], stb[1], we[1], adr[1], sel[1], wdat[1]} = {f.ready, f.err, f.dataout, f.wb_cyc_o, f.wb_stb_o, f.wb_we_o, f.wb_adr_o, f.wb_sel_o, f.wb_dat_o};

  wb_mem_arbiter #(.NUM_PORTS(NP), .BUS_WIDTH(BW), .RR_MODE(1), .MAX_RETRY(MR), .TIMEOUT(TO)) dut_rr (.clk(clk), .rst(rst), .bus(a.master));
  wb_mem_arbiter #(.NUM_PORTS(NP), .BUS_WIDTH(BW), .RR_MODE(0), .MAX_RETRY(MR), .TIMEOUT(TO)) dut_fx (.clk(clk), .rst(rst), .bus(f.master));

  always #5 clk = ~clk;

  function automatic bit is_ack(int r); return r == 1 || r == 4 || r == 5; endfunction
  function automatic bit is_err(int r); return r == 2 || r == 4 || r == 6; endfunction
  function automatic bit is_rty(int r); return r == 3 || r == 5 || r == 6; endfunction
  function automatic int lane_of(logic [31:0] ad); return int'((ad >> 2) % NL); endfunction

  // Outcome of one request given the slave's answer on each successive BUS cycle (rq); cycle 0 = valid seen
  task automatic predict(output int pulse, output int nbus, output bit okr);
    int c, rt, tc, i, r;
    c = 1; rt = 0; tc = 0; i = 0; nbus = 0; okr = 0; pulse = 0;
    while (1) begin
      r = i < rq.size() ? rq[i] : 0;
      i++;
      nbus++;
      if (is_err(r)) begin okr = 0; pulse = c + 1; return; end
      if (is_ack(r)) begin okr = 1; pulse = c + 1; return; end
      if (is_rty(r)) begin
        if (rt < MR) begin rt++; c += 2; tc = 0; continue; end
        okr = 0; pulse = c + 1; return;
      end
      tc++;
      if (tc == TO) begin okr = 0; pulse = c + 1; return; end
      c++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0; wr = '0; addr = '0; datain = '0; rdat = '0;
    ack = 1'b0; berr = 1'b0; rty = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_rr = NP - 1;
    for (int u = 0; u < 2; u++) for (int q = 0; q < NP; q++) exp_dout[u][q] = '0;
  endtask

  // Single request on port p, slave answers from rq; both arbiters see the same single requester
  task automatic transact(input int p, input logic w, input logic [31:0] ad, input logic [31:0] dw, input string nm);
    int pulse, nbus, k, bi, ln, obs, r;
    int seen [2];
    bit okr, bad;
    logic [SW-1:0] es;
    logic [NP-1:0] onehot;
    predict(pulse, nbus, okr);
    ln = lane_of(ad);
    es = {{(SW-4){1'b0}}, 4'hF} << (4 * ln);
    onehot = NP'(1) << p;
    k = 0; bi = 0; obs = -1; seen[0] = 0; seen[1] = 0;
    @(negedge clk);
    checks++;
    if (|{rdy[0], er[0], rdy[1], er[1]}) $display("FAIL %s pulse_width: ready/err still high in idle (%b %b %b %b)", nm, rdy[0], er[0], rdy[1], er[1]);
    valid = '0;
    valid[p] = 1'b1;
    wr[p] = w;
    addr[32*p +: 32] = ad;
    datain[32*p +: 32] = dw;
    while (obs < 0 && k < 64) begin
      @(negedge clk);
      k++;
      ack = 1'b0; berr = 1'b0; rty = 1'b0;
      for (int u = 0; u < 2; u++) if (cyc[u]) begin
        seen[u]++;
        checks++;
        if ({adr[u], sel[u], wdat[u], we[u], stb[u]} !== {ad & ~32'(SW - 1), es, {NL{dw}}, w, 1'b1})
          $display("FAIL %s bus_fields dut%0d: got adr=%h sel=%h we=%b stb=%b dat=%h want adr=%h sel=%h we=%b dat=%h", nm, u, adr[u], sel[u], we[u], stb[u], wdat[u], ad & ~32'(SW - 1), es, w, {NL{dw}});
      end
      if (cyc[0]) begin
        r = bi < rq.size() ? rq[bi] : 0;
        bi++;
        ack = is_ack(r); berr = is_err(r); rty = is_rty(r);
      end
      if (|{rdy[0], er[0], rdy[1], er[1]}) obs = k;
    end
    valid[p] = 1'b0;
    ack = 1'b0; berr = 1'b0; rty = 1'b0;
    last_rr = p;
    checks++;
    if (obs !== pulse) begin failures++; $display("FAIL %s latency: got cycle %0d want cycle %0d", nm, obs, pulse); end
    for (int u = 0; u < 2; u++) begin
      if (okr && !w) exp_dout[u][p] = rdat[32*ln +: 32];
      checks++;
      if (rdy[u] !== (okr ? onehot : '0) || er[u] !== (okr ? '0 : onehot)) begin
        failures++;
        $display("FAIL %s result dut%0d: got ready=%b err=%b want ready=%b err=%b", nm, u, rdy[u], er[u], okr ? onehot : '0, okr ? '0 : onehot);
      end
      checks++;
      if (seen[u] !== nbus || cyc[u] !== 1'b0) begin
        failures++;
        $display("FAIL %s bus_cycles dut%0d: got %0d cycles cyc_now=%b want %0d cycles cyc_now=0", nm, u, seen[u], cyc[u], nbus);
      end
      bad = 0;
      for (int q = 0; q < NP; q++) if (dout[u][32*q +: 32] !== exp_dout[u][q]) bad = 1;
      checks++;
      if (bad) begin failures++; $display("FAIL %s dataout dut%0d: got %h want %h %h %h", nm, u, dout[u], exp_dout[u][2], exp_dout[u][1], exp_dout[u][0]); end
    end
  endtask

  // Ports in mask m held valid for g grants, slave acks every BUS cycle at once
  task automatic arbitrate(input logic [NP-1:0] m, input int g, input string nm);
    int k, n, prev, wrr, wfx, w;
    bit hit, bad;
    k = 0; n = 0; prev = -1;
    for (int q = 0; q < NP; q++) begin
      addr[32*q +: 32] = $urandom;
      datain[32*q +: 32] = $urandom;
      wr[q] = 1'($urandom_range(0, 1));
    end
    rdat = {$urandom, $urandom, $urandom, $urandom};
    valid = m;
    while (n < g && k < 8 * g + 8) begin
      @(negedge clk);
      k++;
      ack = cyc[0];
      if (|{rdy[0], rdy[1], er[0], er[1]}) begin
        wrr = 0; hit = 0;
        for (int s = 1; s <= NP; s++) if (!hit && m[(last_rr + s) % NP]) begin hit = 1; wrr = (last_rr + s) % NP; end
        wfx = 0; hit = 0;
        for (int q = 0; q < NP; q++) if (!hit && m[q]) begin hit = 1; wfx = q; end
        checks++;
        if (rdy[0] !== NP'(1) << wrr || er[0] !== '0) begin failures++; $display("FAIL %s rr_grant: got ready=%b err=%b want ready=%b", nm, rdy[0], er[0], NP'(1) << wrr); end
        checks++;
        if (rdy[1] !== NP'(1) << wfx || er[1] !== '0) begin failures++; $display("FAIL %s fixed_grant: got ready=%b err=%b want ready=%b", nm, rdy[1], er[1], NP'(1) << wfx); end
        if (prev >= 0) begin
          checks++;
          if (k - prev !== 3) begin failures++; $display("FAIL %s spacing: got %0d cycles want 3", nm, k - prev); end
        end
        for (int u = 0; u < 2; u++) begin
          w = u == 0 ? wrr : wfx;
          if (!wr[w]) exp_dout[u][w] = rdat[32*lane_of(addr[32*w +: 32]) +: 32];
          bad = 0;
          for (int q = 0; q < NP; q++) if (dout[u][32*q +: 32] !== exp_dout[u][q]) bad = 1;
          checks++;
          if (bad) begin failures++; $display("FAIL %s dataout dut%0d: got %h want %h %h %h", nm, u, dout[u], exp_dout[u][2], exp_dout[u][1], exp_dout[u][0]); end
        end
        last_rr = wrr;
        prev = k;
        n++;
        if (n == g) valid = '0;
      end
    end
    ack = 1'b0;
    valid = '0;
    checks++;
    if (n !== g) begin failures++; $display("FAIL %s grants: got %0d want %0d", nm, n, g); end
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({rdy[u], er[u], dout[u], cyc[u], stb[u], we[u], adr[u], sel[u], wdat[u]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: got ready=%b err=%b cyc=%b adr=%h sel=%h dout=%h want all zero", u, rdy[u], er[u], cyc[u], adr[u], sel[u], dout[u]);
      end
    end
    @(negedge clk);
    checks++;
    if (cyc[0] !== 1'b0 || cyc[1] !== 1'b0) begin failures++; $display("FAIL reset_idle: got cyc=%b%b want 00", cyc[0], cyc[1]); end
  endtask

  task automatic test_read();
    rq = '{1};
    rdat = {$urandom, 32'hDEADBEEF, $urandom, $urandom};
    transact(0, 1'b0, 32'h0000_1008, $urandom, "read");
    checks++;
    if (dout[0][31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL read_word: got %h want deadbeef", dout[0][31:0]); end
  endtask

  task automatic test_write();
    rq = '{1};
    transact(1, 1'b1, 32'h24, 32'h12345678, "write");
  endtask

  task automatic test_retry();
    rq = '{3, 3, 1};
    rdat = {$urandom, $urandom, $urandom, $urandom};
    transact(2, 1'b0, $urandom, $urandom, "retry_ok");
    rq = '{3, 3, 3, 3};
    transact(0, 1'b0, $urandom, $urandom, "retry_exhaust");
    rq = '{0, 0, 3, 0, 5};
    transact(1, 1'b0, $urandom, $urandom, "retry_idle_mix");
  endtask

  task automatic test_faults();
    rq = '{4};
    transact(1, 1'b0, $urandom, $urandom, "err_with_ack");
    rq = '{6};
    transact(2, 1'b1, $urandom, $urandom, "err_with_rty");
    rq.delete();
    transact(0, 1'b0, $urandom, $urandom, "timeout");
    rq = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1};
    transact(1, 1'b0, $urandom, $urandom, "timeout_reset_by_retry");
  endtask

  task automatic test_round_robin();
    arbitrate(3'b011, 4, "rr_pair");
    arbitrate(3'b111, 6, "rr_all");
    for (int i = 0; i < 6; i++) arbitrate(NP'($urandom_range(1, (1 << NP) - 1)), $urandom_range(2, 6), "rr_rand");
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    valid = 3'b010;
    wr[1] = 1'b0;
    addr[63:32] = $urandom;
    @(negedge clk);
    checks++;
    if (cyc[0] !== 1'b1 || cyc[1] !== 1'b1) begin failures++; $display("FAIL midbus_start: got cyc=%b%b want 11", cyc[0], cyc[1]); end
    rst = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({cyc[u], stb[u], rdy[u], er[u], dout[u]} !== '0) begin
        failures++;
        $display("FAIL midbus_reset dut%0d: got cyc=%b stb=%b ready=%b err=%b dout=%h want zero", u, cyc[u], stb[u], rdy[u], er[u], dout[u]);
      end
    end
    rst = 1'b0;
    last_rr = NP - 1;
    for (int u = 0; u < 2; u++) for (int q = 0; q < NP; q++) exp_dout[u][q] = '0;
    arbitrate(3'b111, 1, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      rq.delete();
      repeat ($urandom_range(0, 4)) rq.push_back($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) rq.push_back($urandom_range(1, 2));
      rdat = {$urandom, $urandom, $urandom, $urandom};
      transact($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)), $urandom, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_retry();
    test_faults();
    test_round_robin();
    test_reset_mid_bus();
    test_random();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
